fpu_issue_ctrl: RTL

- Front-end issue/retire controller placed directly upstream of the fpu block.
- Accepts operand requests over a valid/ready handshake, registers them onto the fpu A/B/opcode inputs, and tracks each in-flight operation through the FPU's fixed latency.
- Captures fpu outp into a result FIFO and returns results, with their tags, over a valid/ready handshake.
- Credit-based issue guarantees no result is ever lost, since the fpu cannot stall.

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fpu_res_fifo.sv | 49 ++++
 rtl/fpu_issue_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU front-end: operand width, opcode encodings and
// the default arithmetic latency of the downstream fpu.
package fpu_pkg;
    localparam int FP_W            = 32;
    localparam int FPU_LAT_DEFAULT = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
endpackage

// File: rtl/fpu_res_fifo.sv
// First-word-fall-through result buffer. DEPTH must be a power of two so the
// pointers wrap naturally.
module fpu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    // Head is masked while empty so the result port reads zero out of reset.
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/retire controller in front of a fixed-latency, non-stallable fpu.
// Credits cover in-flight plus buffered results so no retire is ever dropped.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int FPU_LATENCY = FPU_LAT_DEFAULT,
    parameter int RES_DEPTH   = 4,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [FP_W-1:0]  fpu_a,
    output logic [FP_W-1:0]  fpu_b,
    output logic [1:0]       fpu_op,
    input  logic [FP_W-1:0]  fpu_outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(RES_DEPTH+1);

    logic [CW-1:0]          credit_q, credit_d;
    logic [FP_W-1:0]        fpu_a_q, fpu_b_q;
    logic [1:0]             fpu_op_q;
    logic [FPU_LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]       tag_q [FPU_LATENCY];

    logic                   accept, pop, push;
    logic                   fifo_empty, fifo_full_unused;
    logic [CW-1:0]          fifo_cnt_unused;
    logic [FP_W+TAG_W-1:0]  fifo_rdata;

    // Depends only on registered credit, never on out_ready.
    assign in_ready = !rst && (credit_q < CW'(RES_DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign push     = vld_q[FPU_LATENCY-1];
    assign credit_d = credit_q + CW'(accept) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= '0;
            fpu_a_q  <= '0;
            fpu_b_q  <= '0;
            fpu_op_q <= OP_ADD;
            vld_q    <= '0;
            for (int i = 0; i < FPU_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            credit_q <= credit_d;
            if (accept) begin
                fpu_a_q  <= in_a;
                fpu_b_q  <= in_b;
                fpu_op_q <= in_op;
            end
            vld_q[0] <= accept;
            tag_q[0] <= in_tag;
            for (int i = 1; i < FPU_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    fpu_res_fifo #(
        .DEPTH (RES_DEPTH),
        .W     (FP_W + TAG_W)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({tag_q[FPU_LATENCY-1], fpu_outp}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full_unused),
        .count (fifo_cnt_unused)
    );

    assign fpu_a                 = fpu_a_q;
    assign fpu_b                 = fpu_b_q;
    assign fpu_op                = fpu_op_q;
    assign out_valid             = !fifo_empty;
    assign {out_tag, out_result} = fifo_rdata;
    assign busy                  = (credit_q != '0);
endmodule
